// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM state type shared by the load/store unit.
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane extract/extend for loads and read-modify-write merge for stores.
module lsu_byte_lane (
   input  logic [31:0] word,
   input  logic [31:0] new_data,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] load_data,
   output logic [31:0] merged
);
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] bmask;
   logic [31:0] hmask;
   assign b = word[{lane, 3'b000} +: 8];
   assign h = word[{lane[1], 4'b0000} +: 16];
   assign bmask = 32'h0000_00ff << {lane, 3'b000};
   assign hmask = 32'h0000_ffff << {lane[1], 4'b0000};
   // funct3[2] marks the unsigned variants, so it suppresses sign extension
   assign load_data = funct3[1] ? word
                    : funct3[0] ? {{16{h[15] & ~funct3[2]}}, h}
                    : {{24{b[7] & ~funct3[2]}}, b};
   assign merged = funct3[1] ? new_data
                 : funct3[0] ? (word & ~hmask) | ({2{new_data[15:0]}} & hmask)
                 : (word & ~bmask) | ({4{new_data[7:0]}} & bmask);
endmodule

// File: rtl/lsu_controller.sv
// lsu_controller: sequences RV32I loads/stores onto a word-wide memory without byte enables.
module lsu_controller
   import lsu_pkg::*;
#(
   parameter int WORD_COUNT = 32,
   parameter int IDX_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_data,
   output logic                 resp_err,
   output logic [IDX_WIDTH-1:0] mem_addr,
   output logic                 mem_we,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata
);
   lsu_state_t  state_q, state_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wbuf_q, wbuf_d;
   logic        write_q, write_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] lane_load;
   logic [31:0] lane_merged;
   logic        bad;
   lsu_byte_lane u_lane (
      .word      (mem_rdata),
      .new_data  (wbuf_q),
      .lane      (addr_q[1:0]),
      .funct3    (f3_q),
      .load_data (lane_load),
      .merged    (lane_merged)
   );
   assign bad = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
              || (req_write && req_funct3[2])
              || (req_funct3[1:0] == 2'b01 && req_addr[0])
              || (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
              || ({2'b00, req_addr[31:2]} >= 32'(WORD_COUNT));
   always_comb begin
      state_d     = state_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      wbuf_d      = wbuf_q;
      write_d     = write_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      unique case (state_q)
         IDLE: if (req_valid) begin
            state_d     = bad ? RESP : (req_write && req_funct3 == F3_W) ? WRITE : READ;
            f3_d        = req_funct3;
            addr_d      = req_addr;
            wbuf_d      = req_wdata;
            write_d     = req_write;
            resp_data_d = '0;
            resp_err_d  = bad;
         end
         READ: begin
            state_d     = write_q ? WRITE : RESP;
            wbuf_d      = write_q ? lane_merged : wbuf_q;
            resp_data_d = write_q ? '0 : lane_load;
         end
         WRITE: state_d = RESP;
         RESP: if (resp_ready) begin
            state_d     = IDLE;
            resp_data_d = '0;
            resp_err_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         f3_q        <= '0;
         addr_q      <= '0;
         wbuf_q      <= '0;
         write_q     <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         f3_q        <= f3_d;
         addr_q      <= addr_d;
         wbuf_q      <= wbuf_d;
         write_q     <= write_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end
   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign mem_we     = state_q == WRITE;
   assign mem_wdata  = mem_we ? wbuf_q : '0;
   assign mem_addr   = IDX_WIDTH'(addr_q[31:2]);
endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller: scoreboard bench for lsu_controller against a behavioural word memory.
module tb_lsu_controller;
   import lsu_pkg::*;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_ready = 1'b0, resp_err;
   logic [31:0] resp_data, mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic [31:0] mem [0:31];
   int checks = 0, failures = 0;
   logic [31:0] obs_data;
   logic        obs_err;
   int          obs_lat, obs_we;
   typedef struct {logic [31:0] data; logic err; int lat; int we;} exp_t;
   exp_t sb[$];
   logic [2:0]  ld_f3   [8] = '{F3_W, F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_H, F3_W};
   logic [31:0] ld_addr [8] = '{32'h08, 32'h0B, 32'h0B, 32'h0A, 32'h0A, 32'h09, 32'h08, 32'h7C};
   logic [31:0] ld_mem  [8] = '{32'hDEADBEEF, 32'h80112233, 32'h80112233, 32'h80112233,
                                32'h80112233, 32'h80112233, 32'h80112233, 32'hA5A50F0F};
   logic [31:0] ld_exp  [8] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8011,
                                32'h00008011, 32'h00000022, 32'h00002233, 32'hA5A50F0F};
   logic        st_w    [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [2:0]  st_f3   [8] = '{F3_B, F3_H, F3_H, F3_HU, F3_B, F3_H, F3_W, F3_W};
   logic [31:0] st_addr [8] = '{32'h05, 32'h06, 32'h06, 32'h06, 32'h07, 32'h04, 32'h0C, 32'h7C};
   logic [31:0] st_d    [8] = '{32'hAA, 32'h8001, 32'h0, 32'h0, 32'h1FF, 32'hFFFF5A5A, 32'h12345678, 32'hCAFEF00D};
   logic [31:0] st_rsp  [8] = '{32'h0, 32'h0, 32'hFFFF8001, 32'h00008001, 32'h0, 32'h0, 32'h0, 32'h0};
   int          st_lat  [8] = '{3, 3, 2, 2, 3, 3, 2, 2};
   int          st_idx  [8] = '{1, 1, 1, 1, 1, 1, 3, 31};
   logic [31:0] st_mem  [8] = '{32'h1122AA44, 32'h8001AA44, 32'h8001AA44, 32'h8001AA44,
                                32'hFF01AA44, 32'hFF015A5A, 32'h12345678, 32'hCAFEF00D};
   logic        er_w    [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [2:0]  er_f3   [8] = '{F3_W, F3_H, F3_W, 3'b011, F3_BU, F3_H, F3_B, F3_W};
   logic [31:0] er_addr [8] = '{32'h06, 32'h03, 32'h80, 32'h00, 32'h00, 32'h01, 32'h80, 32'hFFFFFFFC};

   lsu_controller #(.WORD_COUNT(32), .IDX_WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;
   always @(posedge clk) if (mem_we && mem_addr < 32) mem[mem_addr[4:0]] = mem_wdata;

   task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      @(posedge clk); #1 req_valid = 1'b0;
      obs_lat = 0; obs_we = 0;
      for (int k = 1; k <= 10 && obs_lat == 0; k++) begin
         @(negedge clk);
         if (mem_we) obs_we++;
         if (resp_valid) obs_lat = k;
      end
      obs_data = resp_data; obs_err = resp_err;
   endtask

   task automatic ack();
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin failures++;
         $display("FAIL reset_flags got=%b exp=1000", {req_ready, resp_valid, resp_err, mem_we}); end
      checks++; if ({resp_data, mem_addr, mem_wdata} !== 96'h0) begin failures++;
         $display("FAIL reset_buses got=%h/%h/%h exp=0", resp_data, mem_addr, mem_wdata); end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      checks++; if ({req_ready, resp_valid} !== 2'b10) begin failures++;
         $display("FAIL reset_release got=%b exp=10", {req_ready, resp_valid}); end
   endtask

   task automatic test_loads();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         mem[ld_addr[i][6:2]] = ld_mem[i];
         sb.push_back('{ld_exp[i], 1'b0, 2, 0});
         run_req(1'b0, ld_f3[i], ld_addr[i], 32'h0);
         e = sb.pop_front();
         checks++; if ({obs_data, obs_err} !== {e.data, e.err}) begin failures++;
            $display("FAIL load%0d data/err got=%h/%b exp=%h/%b", i, obs_data, obs_err, e.data, e.err); end
         checks++; if (obs_lat != e.lat || obs_we != e.we) begin failures++;
            $display("FAIL load%0d lat/we got=%0d/%0d exp=%0d/%0d", i, obs_lat, obs_we, e.lat, e.we); end
         ack();
      end
   endtask

   task automatic test_stores();
      exp_t e;
      mem[1] = 32'h11223344;
      for (int i = 0; i < 8; i++) begin
         sb.push_back('{st_rsp[i], 1'b0, st_lat[i], st_w[i] ? 1 : 0});
         run_req(st_w[i], st_f3[i], st_addr[i], st_d[i]);
         e = sb.pop_front();
         checks++; if ({obs_data, obs_err} !== {e.data, e.err}) begin failures++;
            $display("FAIL store%0d data/err got=%h/%b exp=%h/%b", i, obs_data, obs_err, e.data, e.err); end
         checks++; if (obs_lat != e.lat || obs_we != e.we) begin failures++;
            $display("FAIL store%0d lat/we got=%0d/%0d exp=%0d/%0d", i, obs_lat, obs_we, e.lat, e.we); end
         checks++; if (mem[st_idx[i]] !== st_mem[i]) begin failures++;
            $display("FAIL store%0d mem[%0d] got=%h exp=%h", i, st_idx[i], mem[st_idx[i]], st_mem[i]); end
         ack();
      end
   endtask

   task automatic test_errors();
      exp_t e;
      logic [31:0] snap [0:31];
      int diffs = 0;
      for (int j = 0; j < 32; j++) snap[j] = mem[j];
      for (int i = 0; i < 8; i++) begin
         sb.push_back('{32'h0, 1'b1, 1, 0});
         run_req(er_w[i], er_f3[i], er_addr[i], 32'hFFFFFFFF);
         e = sb.pop_front();
         checks++; if ({obs_data, obs_err} !== {e.data, e.err}) begin failures++;
            $display("FAIL err%0d data/err got=%h/%b exp=%h/%b", i, obs_data, obs_err, e.data, e.err); end
         checks++; if (obs_lat != e.lat || obs_we != e.we) begin failures++;
            $display("FAIL err%0d lat/we got=%0d/%0d exp=%0d/%0d", i, obs_lat, obs_we, e.lat, e.we); end
         ack();
      end
      for (int j = 0; j < 32; j++) if (mem[j] !== snap[j]) diffs++;
      checks++; if (diffs != 0) begin failures++; $display("FAIL err_mem changed_words got=%0d exp=0", diffs); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      mem[4] = 32'h0BADF00D;
      sb.push_back('{32'h0BADF00D, 1'b0, 2, 0});
      run_req(1'b0, F3_W, 32'h10, 32'h0);
      e = sb.pop_front();
      checks++; if (obs_lat != e.lat) begin failures++; $display("FAIL bp_lat got=%0d exp=%0d", obs_lat, e.lat); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
         checks++; if ({resp_valid, req_ready, mem_we, resp_err, resp_data} !== {4'b1000, e.data}) begin failures++;
            $display("FAIL bp_hold%0d got=%b/%h exp=1000/%h", c, {resp_valid, req_ready, mem_we, resp_err}, resp_data, e.data); end
      end
      req_valid = 1'b0;
      ack();
      checks++; if ({req_ready, resp_valid} !== 2'b10) begin failures++;
         $display("FAIL bp_idle got=%b exp=10", {req_ready, resp_valid}); end
      sb.push_back('{32'h0BADF00D, 1'b0, 2, 0});
      run_req(1'b0, F3_W, 32'h10, 32'h0);
      e = sb.pop_front();
      checks++; if ({obs_data, obs_lat, mem[4]} !== {e.data, e.lat, 32'h0BADF00D}) begin failures++;
         $display("FAIL bp_next got=%h/%0d/%h exp=%h/%0d/0badf00d", obs_data, obs_lat, mem[4], e.data, e.lat); end
      ack();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      mem[3] = 32'h55AA55AA;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h0C; req_wdata = 32'hCAFEBABE;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_mid_we_before got=%b exp=1", mem_we); end
      #1 reset_n = 1'b0;
      #1;
      checks++; if ({mem_we, req_ready, resp_valid, resp_err} !== 4'b0100) begin failures++;
         $display("FAIL rst_mid_flags got=%b exp=0100", {mem_we, req_ready, resp_valid, resp_err}); end
      checks++; if ({resp_data, mem_addr, mem_wdata} !== 96'h0) begin failures++;
         $display("FAIL rst_mid_buses got=%h/%h/%h exp=0", resp_data, mem_addr, mem_wdata); end
      @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      #1;
      checks++; if ({mem[3], req_ready, resp_valid} !== {32'h55AA55AA, 2'b10}) begin failures++;
         $display("FAIL rst_mid_after got=%h/%b exp=55aa55aa/10", mem[3], {req_ready, resp_valid}); end
      sb.push_back('{32'h55AA55AA, 1'b0, 2, 0});
      run_req(1'b0, F3_W, 32'h0C, 32'h0);
      e = sb.pop_front();
      checks++; if ({obs_data, obs_err, obs_lat} !== {e.data, e.err, e.lat}) begin failures++;
         $display("FAIL rst_mid_reload got=%h/%b/%0d exp=%h/%b/%0d", obs_data, obs_err, obs_lat, e.data, e.err, e.lat); end
      ack();
   endtask

   initial begin
      for (int j = 0; j < 32; j++) mem[j] = 32'h01010101 * j;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Load/store sequencer between the RISC-V32I execute stage and the word-wide, single-port data memory (combinational read, synchronous full-word write).
- Turns byte, halfword and word loads/stores into memory cycles. Sub-word stores use a read-modify-write sequence because the memory has no byte enables.
- Checks alignment and range, and returns sign-/zero-extended load data over a valid/ready handshake.

Parameters:
WORD_COUNT, 32, number of 32-bit words in data memory; a word index >= WORD_COUNT is out of range
IDX_WIDTH, 32, width of mem_addr (word index bus)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept a request (IDLE only)
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for B/H)
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal funct3
mem_addr  out  IDX_WIDTH  word index = req_addr[31:2]
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data (combinational from mem_addr)

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low, port reset_n.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_data=0; mem_we=0; mem_addr=0; mem_wdata=0; all captured request registers 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1; a request is accepted on the edge where req_valid & req_ready.
  - funct3, addr and wdata are registered on acceptance.
- Request checks, applied at acceptance:
  - Error if any of: H/HU with addr[0]=1; W with addr[1:0]!=0; addr[31:2] >= WORD_COUNT; funct3 outside {000,001,010,100,101}; store with funct3 100/101.
  - Error -> RESP with resp_err=1, resp_data=0. No memory access; mem_we never asserts.
- Transitions after a legal accept:
  - Load -> READ.
  - SW -> WRITE.
  - SB/SH -> READ, then WRITE.
- READ (1 cycle):
  - mem_addr = captured word index.
  - Load: at the edge, extract the lane from mem_rdata into resp_data, then -> RESP.
  - Sub-word store: at the edge, latch the merged word (mem_rdata with the new byte/half inserted) into the write buffer, then -> WRITE.
- Byte lanes:
  - Little-endian; byte lane = addr[1:0], half lane = addr[1].
  - B/H loads sign-extend bit 7/15; BU/HU zero-extend.
- WRITE (1 cycle):
  - mem_we=1, mem_addr=index, mem_wdata = write buffer (SW: req_wdata verbatim). The memory commits on the edge.
  - Then -> RESP with resp_data=0, resp_err=0.
- RESP:
  - resp_valid=1; resp_data and resp_err held stable until resp_valid & resp_ready.
  - At that edge -> IDLE.
  - req_ready=0 here; no overlap of requests with a pending response.
- Latency, from accept edge to the first cycle resp_valid=1:
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Throughput: one request per (latency + 1) cycles minimum.
- mem_we is decoded from the state register only and is 0 outside WRITE.
- resp_ready asserted outside RESP is ignored. req_valid outside IDLE is ignored; the requester holds it.
- Reset mid-operation:
  - Immediate return to reset values.
  - A write in flight before its commit edge is dropped; no partial write or response.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum lsu_state_t {IDLE, READ, WRITE, RESP}.
- Sub-module lsu_byte_lane (combinational):
  - load extract/extend: word, lane, funct3 -> 32b.
  - store merge: old word, new data, lane, size -> 32b.

Test Plan:
- LW addr 0x08, mem[2]=0xDEADBEEF -> resp_valid 2 cycles after accept, resp_data=0xDEADBEEF, resp_err=0, mem_we never 1.
- LB addr 0x0B and LBU addr 0x0B, mem[2]=0x80112233 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SB addr 0x05 wdata 0xAA, mem[1]=0x11223344 -> exactly one mem_we pulse in cycle 2; mem[1]=0x1122AA44; resp after 3 cycles. Also LH/LHU addr 0x06 after SH 0x8001 -> 0xFFFF8001 / 0x00008001.
- LW addr 0x06, SH addr 0x03, LW addr 0x80 (index 32 >= WORD_COUNT) -> each gives resp_err=1 one cycle after accept, resp_data=0, no mem_we, memory unchanged.
- Backpressure: resp_ready low for 5 cycles after LW -> resp_valid and resp_data stable, req_ready=0; on the handshake, IDLE is reached and the next request is accepted on the following edge.
- reset_n low during WRITE of an SW to index 3 -> mem_we drops asynchronously, mem[3] unchanged, all outputs at reset values, req_ready=1 after release.
